serial_parity_checker: RTL

SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

---
 rtl/serial_parity_pkg.sv | 13 +
 rtl/serial_parity_checker_if.sv | 29 ++
 rtl/serial_parity_checker_sat_counter.sv | 22 ++
 rtl/serial_parity_checker.sv | 118 +++++++++++
 4 files changed

// File: rtl/serial_parity_pkg.sv
// Shared types and default sizing for the serial parity checker slice.
package serial_parity_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_CNT_W  = 8;

endpackage

// File: rtl/serial_parity_checker_if.sv
// Serial bit stream in, checked frames and error statistics out.
interface serial_parity_checker_if #(
    parameter int DATA_W = serial_parity_pkg::DEFAULT_DATA_W,
    parameter int CNT_W  = serial_parity_pkg::DEFAULT_CNT_W
) ();

    logic              x;
    logic              bit_valid;
    logic              sof;
    logic              odd_mode;
    logic              clr_cnt;
    logic              z;
    logic [DATA_W-1:0] data_out;
    logic              frame_valid;
    logic              parity_err;
    logic              abort;
    logic [CNT_W-1:0]  err_count;

    modport master (
        output x, bit_valid, sof, odd_mode, clr_cnt,
        input  z, data_out, frame_valid, parity_err, abort, err_count
    );

    modport slave (
        input  x, bit_valid, sof, odd_mode, clr_cnt,
        output z, data_out, frame_valid, parity_err, abort, err_count
    );

endinterface

// File: rtl/serial_parity_checker_sat_counter.sv
// Saturating event counter; a clear coinciding with an event restarts at one.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= CNT_W'(inc);
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_parity_checker.sv
// Assembles LSB-first serial frames, checks the trailing parity bit and
// counts errored frames.
module serial_parity_checker
    import serial_parity_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic                   clock,
    input  logic                   rst_n,
    serial_parity_checker_if.slave bus
);

    localparam int BC_W = $clog2(DATA_W + 1);

    state_t            state_q, state_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic              z_q, z_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              fv_q, fv_d;
    logic              perr_q, perr_d;
    logic              abort_q, abort_d;
    logic              err_inc;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            z_q       <= 1'b0;
            mode_q    <= 1'b0;
            shift_q   <= '0;
            data_q    <= '0;
            fv_q      <= 1'b0;
            perr_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            z_q       <= z_d;
            mode_q    <= mode_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            fv_q      <= fv_d;
            perr_q    <= perr_d;
            abort_q   <= abort_d;
        end
    end

    // A qualified sof always restarts a frame, abandoning one in flight.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        z_d       = z_q;
        mode_d    = mode_q;
        shift_d   = shift_q;
        data_d    = data_q;
        fv_d      = 1'b0;
        perr_d    = perr_q;
        abort_d   = 1'b0;
        err_inc   = 1'b0;

        if (bus.bit_valid) begin
            if (bus.sof) begin
                abort_d   = (state_q != IDLE);
                shift_d   = DATA_W'(bus.x);
                z_d       = bus.x;
                bit_cnt_d = BC_W'(1);
                mode_d    = bus.odd_mode;
                state_d   = DATA;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d = IDLE;
                    end
                    DATA: begin
                        // shift_q is cleared at sof, so OR-ing in places the bit.
                        shift_d   = shift_q | (DATA_W'(bus.x) << bit_cnt_q);
                        z_d       = z_q ^ bus.x;
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                        if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
                            state_d = PAR;
                        end
                    end
                    PAR: begin
                        fv_d      = 1'b1;
                        data_d    = shift_q;
                        perr_d    = z_q ^ bus.x ^ mode_q;
                        err_inc   = perr_d;
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clock (clock),
        .rst_n (rst_n),
        .inc   (err_inc),
        .clr   (bus.clr_cnt),
        .count (bus.err_count)
    );

    assign bus.z           = z_q;
    assign bus.data_out    = data_q;
    assign bus.frame_valid = fv_q;
    assign bus.parity_err  = perr_q;
    assign bus.abort       = abort_q;

endmodule
